// File: rtl/soc_bus_pkg.sv
// -----------------------------------------------------------------------------
// soc_bus_pkg
// Shared definitions for the soc_bus interconnect:
//   - state_t       : bus controller FSM states
//   - RAM_* / BUTTON_* : default memory map (RAM region plus one button register)
//   - cnt_width()   : width of the wait-state counter for a given timeout
// -----------------------------------------------------------------------------
package soc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default memory map: RAM covers [0, 411700), the button register is the
    // single word at 411700.
    localparam logic [31:0] RAM_BASE     = 32'd0;
    localparam logic [31:0] RAM_LIMIT    = 32'd411700;
    localparam logic [31:0] BUTTON_ADDR  = 32'd411700;
    localparam logic [31:0] BUTTON_LIMIT = BUTTON_ADDR + 32'd1;

    // The counter only has to hold values up to timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/bus_decoder.sv
// -----------------------------------------------------------------------------
// bus_decoder
// Combinational address decoder. Compares the address against every slave
// region [SLAVE_BASE[i], SLAVE_LIMIT[i]) at full address width, unsigned.
// Overlapping regions resolve to the lowest slave index.
// Ports:
//   addr : address to decode
//   sel  : one-hot slave select (all zero on a miss)
//   hit  : address falls inside at least one region
// -----------------------------------------------------------------------------
module bus_decoder
    import soc_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_SLAVES = 2,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE  [NUM_SLAVES] = '{RAM_BASE, BUTTON_ADDR},
    parameter logic [ADDR_WIDTH-1:0] SLAVE_LIMIT [NUM_SLAVES] = '{RAM_LIMIT, BUTTON_LIMIT}
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    always_comb begin
        // NOTE: every output gets a default before the loop; a path that left
        // sel or hit unassigned would infer a latch.
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            // Once a lower index has matched, higher indices are masked off.
            if (!hit && (addr >= SLAVE_BASE[i]) && (addr < SLAVE_LIMIT[i])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_bus.sv
// -----------------------------------------------------------------------------
// soc_bus
// Single-master, multi-slave bus controller. A request in IDLE is decoded;
// a hit registers the transfer and drives it to the selected slave (ACCESS)
// until that slave answers or the wait counter expires; a miss answers the
// master directly with an error. RESP is a one-cycle completion pulse.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   master_req/write/addr/wdata : master request, held until master_ready
//   master_rdata        : read data, valid with master_ready
//   master_ready        : one-cycle completion pulse
//   master_error        : qualifies master_ready (unmapped address / timeout)
//   slave_sel           : one-hot select, non-zero only in ACCESS
//   slave_write/addr/wdata : registered transfer, broadcast to all slaves
//   slave_rdata         : per-slave read data
//   slave_ready         : per-slave completion
// -----------------------------------------------------------------------------
module soc_bus
    import soc_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SLAVES = 2,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE  [NUM_SLAVES] = '{RAM_BASE, BUTTON_ADDR},
    parameter logic [ADDR_WIDTH-1:0] SLAVE_LIMIT [NUM_SLAVES] = '{RAM_LIMIT, BUTTON_LIMIT},
    parameter int                    TIMEOUT    = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  master_req,
    input  logic                                  master_write,
    input  logic [ADDR_WIDTH-1:0]                 master_addr,
    input  logic [DATA_WIDTH-1:0]                 master_wdata,
    output logic [DATA_WIDTH-1:0]                 master_rdata,
    output logic                                  master_ready,
    output logic                                  master_error,
    output logic [NUM_SLAVES-1:0]                 slave_sel,
    output logic                                  slave_write,
    output logic [ADDR_WIDTH-1:0]                 slave_addr,
    output logic [DATA_WIDTH-1:0]                 slave_wdata,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] slave_rdata,
    input  logic [NUM_SLAVES-1:0]                 slave_ready
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;

    bus_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_SLAVES  (NUM_SLAVES),
        .SLAVE_BASE  (SLAVE_BASE),
        .SLAVE_LIMIT (SLAVE_LIMIT)
    ) u_decoder (
        .addr (master_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // The registered select doubles as the response mask: only the selected
    // slave's ready and data are visible, and it is all zero outside ACCESS.
    always_comb begin
        sel_ready = |(slave_sel & slave_ready);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slave_sel[i]) begin
                sel_rdata = sel_rdata | slave_rdata[i];
            end
        end
    end

    // NOTE: state and outputs are registers, so they are assigned with <=
    // only; blocking assignments here would race against readers of the
    // same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the datapath copies (slave_addr, slave_wdata, master_rdata)
            // are reset as well, because they are visible outputs that must
            // read zero straight after reset.
            state        <= ST_IDLE;
            cnt          <= '0;
            master_rdata <= '0;
            master_ready <= 1'b0;
            master_error <= 1'b0;
            slave_sel    <= '0;
            slave_write  <= 1'b0;
            slave_addr   <= '0;
            slave_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    master_ready <= 1'b0;
                    master_error <= 1'b0;
                    master_rdata <= '0;
                    if (master_req) begin
                        if (dec_hit) begin
                            slave_sel   <= dec_sel;
                            slave_write <= master_write;
                            slave_addr  <= master_addr;
                            slave_wdata <= master_wdata;
                            cnt         <= '0;
                            state       <= ST_ACCESS;
                        end else begin
                            // Unmapped: answer the master without touching
                            // any slave.
                            master_ready <= 1'b1;
                            master_error <= 1'b1;
                            state        <= ST_RESP;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (sel_ready) begin
                        // A ready in the last allowed cycle still completes.
                        master_ready <= 1'b1;
                        master_error <= 1'b0;
                        master_rdata <= slave_write ? '0 : sel_rdata;
                        slave_sel    <= '0;
                        slave_write  <= 1'b0;
                        state        <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        master_ready <= 1'b1;
                        master_error <= 1'b1;
                        master_rdata <= '0;
                        slave_sel    <= '0;
                        slave_write  <= 1'b0;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    // Requests are ignored here; the next one is taken in IDLE.
                    master_ready <= 1'b0;
                    master_error <= 1'b0;
                    master_rdata <= '0;
                    state        <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus.sv
// -----------------------------------------------------------------------------
// tb_soc_bus
// Directed bench for soc_bus with the default memory map and TIMEOUT=16.
// A table of transfers (request, slave response schedule, expected result) is
// applied in a loop; reset abort and back-to-back transfers are hand-written.
// -----------------------------------------------------------------------------
module tb_soc_bus;
    import soc_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int TO = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  master_req;
    logic                  master_write;
    logic [AW-1:0]         master_addr;
    logic [DW-1:0]         master_wdata;
    logic [DW-1:0]         master_rdata;
    logic                  master_ready;
    logic                  master_error;
    logic [NS-1:0]         slave_sel;
    logic                  slave_write;
    logic [AW-1:0]         slave_addr;
    logic [DW-1:0]         slave_wdata;
    logic [NS-1:0][DW-1:0] slave_rdata;
    logic [NS-1:0]         slave_ready;

    always #5 clock = ~clock;

    soc_bus #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SLAVES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .master_req   (master_req),
        .master_write (master_write),
        .master_addr  (master_addr),
        .master_wdata (master_wdata),
        .master_rdata (master_rdata),
        .master_ready (master_ready),
        .master_error (master_error),
        .slave_sel    (slave_sel),
        .slave_write  (slave_write),
        .slave_addr   (slave_addr),
        .slave_wdata  (slave_wdata),
        .slave_rdata  (slave_rdata),
        .slave_ready  (slave_ready)
    );

    // delay: ACCESS cycle (1-based) in which the target slave raises ready,
    // 0 = never. spurious: the other slave holds ready high throughout.
    // exp_lat: cycles from the request cycle to the master_ready cycle.
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            slave;
        int            delay;
        logic          spurious;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [NS-1:0] exp_sel;
    } vec_t;

    vec_t vecs [13];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " master_rdata"}, master_rdata, '0);
        check({tag, " master_ready"}, master_ready, 1'b0);
        check({tag, " master_error"}, master_error, 1'b0);
        check({tag, " slave_sel"},    slave_sel,    '0);
        check({tag, " slave_write"},  slave_write,  1'b0);
        check({tag, " slave_addr"},   slave_addr,   '0);
        check({tag, " slave_wdata"},  slave_wdata,  '0);
    endtask

    // Called at a negedge: issues the request in the current cycle, plays the
    // slave side from the vector's schedule and compares the outcome.
    task automatic run_txn(input vec_t v, input int idx);
        int            lat;
        int            acc;
        logic [NS-1:0] sel_or;
        logic          bus_bad;
        logic          done;
        logic [DW-1:0] got_rd;
        logic          got_err;
        int            exp_acc;

        master_req   = 1'b1;
        master_write = v.write;
        master_addr  = v.addr;
        master_wdata = v.wdata;
        slave_rdata[0] = v.rd0;
        slave_rdata[1] = v.rd1;
        slave_ready  = '0;
        lat = 0; acc = 0; sel_or = '0; bus_bad = 1'b0; done = 1'b0;
        got_rd = '0; got_err = 1'b0;

        for (int t = 1; t <= 40 && !done; t++) begin
            @(negedge clock);
            if (master_ready) begin
                lat     = t;
                got_rd  = master_rdata;
                got_err = master_error;
                done    = 1'b1;
                if (slave_sel !== '0 || slave_write !== 1'b0) bus_bad = 1'b1;
                master_req  = 1'b0;
                slave_ready = '0;
            end else begin
                if (slave_sel !== '0) begin
                    acc++;
                    sel_or = sel_or | slave_sel;
                    if (slave_addr !== v.addr || slave_wdata !== v.wdata ||
                        slave_write !== v.write) bus_bad = 1'b1;
                end else if (slave_write !== 1'b0) begin
                    bus_bad = 1'b1;
                end
                slave_ready = '0;
                if (v.spurious) slave_ready[1 - v.slave] = 1'b1;
                if (t == v.delay) slave_ready[v.slave] = 1'b1;
            end
        end
        master_req  = 1'b0;
        slave_ready = '0;

        exp_acc = (v.exp_sel != '0) ? v.exp_lat - 1 : 0;
        check($sformatf("v%0d latency", idx),       lat,     v.exp_lat);
        check($sformatf("v%0d rdata", idx),         got_rd,  v.exp_rdata);
        check($sformatf("v%0d error", idx),         got_err, v.exp_err);
        check($sformatf("v%0d slave_sel", idx),     sel_or,  v.exp_sel);
        check($sformatf("v%0d access cycles", idx), acc,     exp_acc);
        check($sformatf("v%0d bus signals", idx),   bus_bad, 1'b0);

        @(negedge clock);
        check($sformatf("v%0d ready one cycle", idx), master_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1_t, p2_t, pulses;
        logic [DW-1:0] p1_rd, p2_rd;

        //           wr    addr           wdata         sl dly sp    rd0           rd1           lat rdata         err   sel
        vecs[0]  = '{1'b0, 32'd100,       32'h0,        0, 1,  1'b0, 32'hDEADBEEF, 32'h11111111, 2,  32'hDEADBEEF, 1'b0, 2'b01};
        vecs[1]  = '{1'b1, 32'd411700,    32'h12,       1, 1,  1'b0, 32'hAAAA0000, 32'hBBBB0000, 2,  32'h0,        1'b0, 2'b10};
        vecs[2]  = '{1'b0, 32'd411701,    32'h0,        0, 1,  1'b0, 32'hDEADBEEF, 32'h11111111, 1,  32'h0,        1'b1, 2'b00};
        vecs[3]  = '{1'b0, 32'd0,         32'h0,        0, 3,  1'b0, 32'h01234567, 32'h11111111, 4,  32'h01234567, 1'b0, 2'b01};
        vecs[4]  = '{1'b0, 32'd411699,    32'h0,        0, 1,  1'b0, 32'h0BADF00D, 32'h11111111, 2,  32'h0BADF00D, 1'b0, 2'b01};
        vecs[5]  = '{1'b0, 32'd411700,    32'h0,        1, 2,  1'b0, 32'hFFFFFFFF, 32'h000055AA, 3,  32'h000055AA, 1'b0, 2'b10};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'h0,        0, 1,  1'b0, 32'hDEADBEEF, 32'h11111111, 1,  32'h0,        1'b1, 2'b00};
        vecs[7]  = '{1'b0, 32'd100,       32'h0,        0, 2,  1'b1, 32'h13579BDF, 32'h2468ACE0, 3,  32'h13579BDF, 1'b0, 2'b01};
        vecs[8]  = '{1'b0, 32'd200,       32'h0,        0, 0,  1'b1, 32'hDEADBEEF, 32'h22222222, 17, 32'h0,        1'b1, 2'b01};
        vecs[9]  = '{1'b0, 32'd300,       32'h0,        0, 16, 1'b0, 32'hCAFEF00D, 32'h11111111, 17, 32'hCAFEF00D, 1'b0, 2'b01};
        vecs[10] = '{1'b1, 32'd400,       32'hA5A5A5A5, 0, 1,  1'b0, 32'hFFFF0000, 32'h11111111, 2,  32'h0,        1'b0, 2'b01};
        vecs[11] = '{1'b0, 32'h80064834,  32'h0,        0, 1,  1'b0, 32'hDEADBEEF, 32'h11111111, 1,  32'h0,        1'b1, 2'b00};
        vecs[12] = '{1'b1, 32'd411701,    32'h77,       1, 1,  1'b0, 32'hDEADBEEF, 32'h11111111, 1,  32'h0,        1'b1, 2'b00};

        reset        = 1'b1;
        master_req   = 1'b0;
        master_write = 1'b0;
        master_addr  = '0;
        master_wdata = '0;
        slave_rdata  = '0;
        slave_ready  = '0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");

        // Release reset and request in the same cycle: the first edge with
        // reset low must accept it (vector 0 checks the 3-cycle latency).
        reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset in the second ACCESS cycle of a read nobody answers.
        master_req   = 1'b1;
        master_write = 1'b0;
        master_addr  = 32'd100;
        master_wdata = '0;
        slave_ready  = '0;
        @(negedge clock);
        check("abort access1 sel", slave_sel, 2'b01);
        @(negedge clock);
        check("abort access2 sel", slave_sel, 2'b01);
        reset      = 1'b1;
        master_req = 1'b0;
        @(negedge clock);
        check_outputs_zero("abort");
        reset = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (master_ready) pulses++;
        end
        check("abort no ready pulse", pulses, 0);
        run_txn(vecs[0], 100);

        // Back-to-back: slave0 then slave1 with master_req held high.
        master_req   = 1'b1;
        master_write = 1'b0;
        master_addr  = 32'd100;
        slave_rdata[0] = 32'h11110000;
        slave_rdata[1] = 32'h22220000;
        pulses = 0; p1_t = 0; p2_t = 0; p1_rd = '0; p2_rd = '0;
        for (int t = 1; t <= 30 && pulses < 2; t++) begin
            @(negedge clock);
            slave_ready = slave_sel;
            if (master_ready) begin
                pulses++;
                if (pulses == 1) begin
                    p1_t = t; p1_rd = master_rdata;
                    master_addr = 32'd411700;
                end else begin
                    p2_t = t; p2_rd = master_rdata;
                    master_req = 1'b0;
                end
            end
        end
        slave_ready = '0;
        master_req  = 1'b0;
        check("b2b pulses",       pulses, 2);
        check("b2b first pulse",  p1_t,   2);
        check("b2b second pulse", p2_t,   5);
        check("b2b first rdata",  p1_rd,  32'h11110000);
        check("b2b second rdata", p2_rd,  32'h22220000);
        @(negedge clock);
        check("b2b ready low after", master_ready, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/soc_bus.md
SOC_BUS -- requirements
Module: soc_bus

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width.
REQ-003 SHALL have parameter NUM_SLAVES, default 2, the slave count (1..8).
REQ-004 SHALL have parameter SLAVE_BASE[NUM_SLAVES], default {0, 411700}, the inclusive region base per slave.
REQ-005 SHALL have parameter SLAVE_LIMIT[NUM_SLAVES], default {411700, 411701}, the exclusive region limit per slave.
REQ-006 SHALL have parameter TIMEOUT, default 16, the maximum cycles spent waiting for slave_ready.
REQ-007 SHALL have ports clock (in, 1, single clock) and reset (in, 1, synchronous, active-high).
REQ-008 SHALL have port master_req (in, 1): transfer request, held by the master until master_ready.
REQ-009 SHALL have port master_write (in, 1): 1 = write, 0 = read.
REQ-010 SHALL have ports master_addr (in, ADDR_WIDTH) and master_wdata (in, DATA_WIDTH).
REQ-011 SHALL have port master_rdata (out, DATA_WIDTH): read data, valid while master_ready is high.
REQ-012 SHALL have port master_ready (out, 1): single-cycle completion pulse.
REQ-013 SHALL have port master_error (out, 1): qualifies master_ready; signals an unmapped address or a timeout.
REQ-014 SHALL have port slave_sel (out, NUM_SLAVES): one-hot select.
REQ-015 SHALL have ports slave_write (out, 1), slave_addr (out, ADDR_WIDTH) and slave_wdata (out, DATA_WIDTH), broadcast to all slaves.
REQ-016 SHALL have port slave_rdata (in, NUM_SLAVES x DATA_WIDTH): per-slave read data.
REQ-017 SHALL have port slave_ready (in, NUM_SLAVES): per-slave completion.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-019 IDLE with master_req=1 SHALL decode master_addr; a hit is SLAVE_BASE[i] <= addr < SLAVE_LIMIT[i], and on overlapping regions the lowest index wins.
REQ-020 On a decode hit, the block SHALL register addr, wdata, write and the one-hot select, then go to ACCESS.
REQ-021 On a decode miss, the block SHALL go directly to RESP with error=1 and rdata=0, and SHALL assert no slave_sel.
REQ-022 In ACCESS, slave_sel, slave_write, slave_addr and slave_wdata SHALL be driven only from the registered copies and held stable.
REQ-023 In ACCESS, slave_ready of the selected slave SHALL capture that slave's slave_rdata (0 for writes) and move the FSM to RESP with error=0; ready from unselected slaves SHALL be ignored.
REQ-024 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; reaching TIMEOUT-1 without ready SHALL move the FSM to RESP with error=1 and rdata=0.
REQ-025 RESP SHALL last exactly one cycle with master_ready=1, then return to IDLE; master_req seen during RESP SHALL NOT start a transfer.
REQ-026 Minimum latency SHALL be 3 cycles: request at cycle N, slave_ready at N+1, master_ready at N+2.
REQ-027 Back-to-back transfers SHALL be accepted on the first IDLE cycle after RESP.
REQ-028 Outside ACCESS, slave_sel SHALL be 0 and slave_write SHALL be 0.
REQ-029 Slave write data SHALL be committed by the slave in the cycle where sel, write and ready are all high.
REQ-030 Address comparisons SHALL be unsigned at full ADDR_WIDTH, with no truncation.

Reset
REQ-031 Reset SHALL force state IDLE, the counter to 0, and every output (master_rdata, master_ready, master_error, slave_sel, slave_write, slave_addr, slave_wdata) to 0 on the next clock edge.
REQ-032 Reset asserted during ACCESS or RESP SHALL abort the transfer without a master_ready pulse.
REQ-033 The first request SHALL be accepted on the first cycle after reset deasserts.

Structure
REQ-034 Package soc_bus_pkg SHALL hold the state enum, the default memory-map constants (RAM_BASE=0, RAM_LIMIT=411700, BUTTON_ADDR=411700) and the counter-width function.
REQ-035 Address decoding SHALL be a separate combinational sub-module, bus_decoder (address to one-hot plus hit), instantiated once.
REQ-036 Expected size is 150-300 lines of RTL, with no latches and all outputs registered.

Verification
REQ-037 Read of 100 with slave0 ready after 1 cycle returning 0xDEADBEEF -> master_ready at N+2, rdata 0xDEADBEEF, error 0.
REQ-038 Write 0x12 to 411700 -> only slave_sel[1] asserted, slave_wdata 0x12, slave0 sees no select; completes with error 0.
REQ-039 Read of 411701 (unmapped) -> master_ready at N+1, error 1, rdata 0, slave_sel stays 0.
REQ-040 Slave0 never ready -> error pulse after exactly TIMEOUT ACCESS cycles (16), FSM back in IDLE.
REQ-041 Reset asserted in the second ACCESS cycle -> no master_ready pulse, all outputs 0 next cycle, and a fresh read completes normally.
REQ-042 Two back-to-back reads (slave0, then slave1) with master_req held -> two master_ready pulses separated by exactly one IDLE cycle.
